// File: rtl/tcdm_amo_pkg.sv
// Shared AMO definitions for the core-side initiator and the bank-side AMO shim.
// Opcode numbering must match the shim exactly.
package tcdm_amo_pkg;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOCAS  = 4'hA
   } amo_op_t;

   localparam int unsigned AmoWordBytes = 4;
   localparam logic [3:0]  AmoOpMax     = AMOCAS;

   function automatic logic is_amo(input logic [3:0] op);
      return op != AMONone;
   endfunction

endpackage

// File: rtl/amo_req_encoder.sv
// Combinational encoder: 32-bit core request -> 64-bit bank lane format,
// plus legality check (misaligned AMO, high-lane CAS, unknown opcode).
module amo_req_encoder
   import tcdm_amo_pkg::*;
(
   input  logic [3:0]                  op_i,
   input  logic [2:0]                  addr_i,
   input  logic                        wen_i,
   input  logic [31:0]                 wdata_i,
   input  logic [31:0]                 swap_i,
   input  logic [AmoWordBytes-1:0]     be_i,
   output logic [63:0]                 wdata_o,
   output logic [2*AmoWordBytes-1:0]   be_o,
   output logic                        wen_o,
   output logic                        illegal_o
);

   logic hi;
   logic misaligned;

   assign hi         = addr_i[2];
   assign misaligned = (addr_i[1:0] != 2'b00);

   always_comb begin
      wdata_o   = {wdata_i, wdata_i};
      be_o      = hi ? {be_i, 4'h0} : {4'h0, be_i};
      wen_o     = 1'b0;
      illegal_o = 1'b0;
      if (op_i > AmoOpMax) begin
         illegal_o = 1'b1;
      end else if (op_i == AMOCAS) begin
         // CAS always occupies the low lane; the new value rides in the high half.
         be_o      = 8'h0F;
         wdata_o   = {swap_i, wdata_i};
         illegal_o = hi | misaligned;
      end else if (is_amo(op_i)) begin
         be_o      = hi ? 8'hF0 : 8'h0F;
         illegal_o = misaligned;
      end else begin
         wen_o     = wen_i;
      end
   end

endmodule

// File: rtl/amo_initiator.sv
// Core-side bank master: one outstanding load/store/AMO, encoded into the
// 64-bit bank format, with the 32-bit old value returned on a response channel.
module amo_initiator
   import tcdm_amo_pkg::*;
#(
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned AddrMemWidth = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [AddrWidth-1:0]    req_addr_i,
   input  logic [3:0]              req_amo_i,
   input  logic                    req_wen_i,
   input  logic [31:0]             req_wdata_i,
   input  logic [31:0]             req_swap_i,
   input  logic [3:0]              req_be_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [31:0]             resp_rdata_o,
   output logic                    resp_err_o,
   output logic                    out_req_o,
   input  logic                    out_gnt_i,
   output logic [AddrMemWidth-1:0] out_add_o,
   output logic [3:0]              out_amo_o,
   output logic                    out_wen_o,
   output logic [63:0]             out_wdata_o,
   output logic [7:0]              out_be_o,
   input  logic [63:0]             out_rdata_i
);

   localparam int unsigned ExtW = AddrMemWidth + 3;

   typedef enum logic [1:0] {StIdle, StIssue, StRdata, StResp} state_t;

   state_t                  state_q, state_d;
   logic [AddrMemWidth-1:0] add_q, add_d;
   logic [3:0]              amo_q, amo_d;
   logic                    wen_q, wen_d;
   logic [63:0]             wdata_q, wdata_d;
   logic [7:0]              be_q, be_d;
   logic                    hi_q, hi_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic [ExtW-1:0]         addr_ext;
   logic [63:0]             enc_wdata;
   logic [7:0]              enc_be;
   logic                    enc_wen;
   logic                    enc_illegal;

   // Byte address is zero-extended when narrower than the bank word address needs.
   generate
      if (AddrWidth >= ExtW) begin : gen_addr_trunc
         assign addr_ext = req_addr_i[ExtW-1:0];
      end else begin : gen_addr_pad
         assign addr_ext = {{(ExtW - AddrWidth){1'b0}}, req_addr_i};
      end
   endgenerate

   amo_req_encoder u_encoder (
      .op_i      (req_amo_i),
      .addr_i    (addr_ext[2:0]),
      .wen_i     (req_wen_i),
      .wdata_i   (req_wdata_i),
      .swap_i    (req_swap_i),
      .be_i      (req_be_i),
      .wdata_o   (enc_wdata),
      .be_o      (enc_be),
      .wen_o     (enc_wen),
      .illegal_o (enc_illegal)
   );

   always_comb begin
      state_d      = state_q;
      add_d        = add_q;
      amo_d        = amo_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      hi_d         = hi_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      out_req_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               add_d   = addr_ext[ExtW-1:3];
               amo_d   = req_amo_i;
               wen_d   = enc_wen;
               wdata_d = enc_wdata;
               be_d    = enc_be;
               hi_d    = addr_ext[2];
               err_d   = enc_illegal;
               rdata_d = '0;
               state_d = enc_illegal ? StResp : StIssue;
            end
         end
         StIssue: begin
            out_req_o = 1'b1;
            if (out_gnt_i) begin
               state_d = StRdata;
            end
         end
         StRdata: begin
            // Stores report zero; everything else returns the addressed 32-bit lane.
            rdata_d = wen_q ? 32'h0 : (hi_q ? out_rdata_i[63:32] : out_rdata_i[31:0]);
            state_d = StResp;
         end
         StResp: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         add_q   <= '0;
         amo_q   <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         hi_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         add_q   <= add_d;
         amo_q   <= amo_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         hi_q    <= hi_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign out_add_o    = add_q;
   assign out_amo_o    = amo_q;
   assign out_wen_o    = wen_q;
   assign out_wdata_o  = wdata_q;
   assign out_be_o     = be_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule

// File: tb/tb_amo_initiator.sv
// Directed bench for amo_initiator with a small behavioural AMO bank that
// withholds grant for one cycle after every AMO.
module tb_amo_initiator;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [3:0]  req_amo_i;
   logic        req_wen_i;
   logic [31:0] req_wdata_i;
   logic [31:0] req_swap_i;
   logic [3:0]  req_be_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        out_req_o;
   logic        out_gnt_i;
   logic [31:0] out_add_o;
   logic [3:0]  out_amo_o;
   logic        out_wen_o;
   logic [63:0] out_wdata_o;
   logic [7:0]  out_be_o;
   logic [63:0] out_rdata_i;

   int n_cmp = 0;
   int n_bad = 0;

   logic        gnt_en;
   logic        block_q;
   logic        bank_init;
   logic [63:0] mem [0:63];

   always #5 clk_i = ~clk_i;

   amo_initiator #(.AddrWidth(32), .AddrMemWidth(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_amo_i    (req_amo_i),
      .req_wen_i    (req_wen_i),
      .req_wdata_i  (req_wdata_i),
      .req_swap_i   (req_swap_i),
      .req_be_i     (req_be_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .out_req_o    (out_req_o),
      .out_gnt_i    (out_gnt_i),
      .out_add_o    (out_add_o),
      .out_amo_o    (out_amo_o),
      .out_wen_o    (out_wen_o),
      .out_wdata_o  (out_wdata_o),
      .out_be_o     (out_be_o),
      .out_rdata_i  (out_rdata_i)
   );

   function automatic logic [63:0] bank_apply(input logic [63:0] old, input logic [3:0] amo,
                                              input logic wen, input logic [63:0] wd,
                                              input logic [7:0] be);
      logic [63:0] res;
      res = old;
      case (amo)
         4'h0: if (wen) for (int b = 0; b < 8; b++) if (be[b]) res[b*8 +: 8] = wd[b*8 +: 8];
         4'h1: for (int b = 0; b < 8; b++) if (be[b]) res[b*8 +: 8] = wd[b*8 +: 8];
         4'h2: if (be[0]) res[31:0] = old[31:0] + wd[31:0];
               else       res[63:32] = old[63:32] + wd[63:32];
         4'hA: if (old[31:0] == wd[31:0]) res[31:0] = wd[63:32];
         default: ;
      endcase
      return res;
   endfunction

   assign out_gnt_i = gnt_en && !block_q;

   always @(posedge clk_i) begin
      if (bank_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 64'h0;
         mem[6'h00]  <= 64'h00000005_00000007;
         mem[6'h20]  <= 64'h0000000A_00000003;
         mem[6'h21]  <= 64'h11112222_33334444;
         out_rdata_i <= 64'h0;
         block_q     <= 1'b0;
      end else begin
         block_q <= 1'b0;
         if (out_req_o && out_gnt_i) begin
            out_rdata_i          <= mem[out_add_o[5:0]];
            mem[out_add_o[5:0]]  <= bank_apply(mem[out_add_o[5:0]], out_amo_o, out_wen_o,
                                               out_wdata_o, out_be_o);
            block_q              <= (out_amo_o != 4'h0);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input logic [31:0] addr, input logic [3:0] amo, input logic wen,
                            input logic [31:0] wd, input logic [31:0] sw, input logic [3:0] be);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_amo_i   = amo;
      req_wen_i   = wen;
      req_wdata_i = wd;
      req_swap_i  = sw;
      req_be_i    = be;
   endtask

   task automatic run_txn(input string tag, input logic [31:0] addr, input logic [3:0] amo,
                          input logic wen, input logic [31:0] wd, input logic [31:0] sw,
                          input logic [3:0] be, input logic [7:0] exp_be,
                          input logic [63:0] exp_wd, input logic exp_wen,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int stall, input int hold);
      int lat;
      chk({tag, "/ready_idle"}, 64'(req_ready_o), 64'd1);
      resp_ready_i = 1'b0;
      drive_req(addr, amo, wen, wd, sw, be);
      tick();
      req_valid_i = 1'b0;
      chk({tag, "/ready_busy"}, 64'(req_ready_o), 64'd0);
      if (!exp_err) begin
         chk({tag, "/out_req"}, 64'(out_req_o), 64'd1);
         chk({tag, "/out_add"}, 64'(out_add_o), 64'(addr >> 3));
         chk({tag, "/out_amo"}, 64'(out_amo_o), 64'(amo));
         chk({tag, "/out_be"},  64'(out_be_o),  64'(exp_be));
         chk({tag, "/out_wdata"}, out_wdata_o, exp_wd);
         chk({tag, "/out_wen"}, 64'(out_wen_o), 64'(exp_wen));
         if (stall > 0) gnt_en = 1'b0;
         for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "/stall_req"},   64'(out_req_o), 64'd1);
            chk({tag, "/stall_be"},    64'(out_be_o),  64'(exp_be));
            chk({tag, "/stall_wdata"}, out_wdata_o,    exp_wd);
            chk({tag, "/stall_add"},   64'(out_add_o), 64'(addr >> 3));
         end
         gnt_en = 1'b1;
      end else begin
         chk({tag, "/no_out_req"}, 64'(out_req_o), 64'd0);
      end
      lat = 0;
      while (!resp_valid_o && lat < 20) begin
         tick();
         lat++;
         if (exp_err) chk({tag, "/err_out_req"}, 64'(out_req_o), 64'd0);
      end
      chk({tag, "/latency"}, 64'(lat), exp_err ? 64'd0 : 64'd2);
      chk({tag, "/resp_valid"}, 64'(resp_valid_o), 64'd1);
      chk({tag, "/rdata"}, 64'(resp_rdata_o), 64'(exp_rd));
      chk({tag, "/err"}, 64'(resp_err_o), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "/hold_valid"}, 64'(resp_valid_o), 64'd1);
         chk({tag, "/hold_rdata"}, 64'(resp_rdata_o), 64'(exp_rd));
         chk({tag, "/hold_ready"}, 64'(req_ready_o),  64'd0);
         chk({tag, "/hold_noreq"}, 64'(out_req_o),    64'd0);
      end
      resp_ready_i = 1'b1;
      tick();
      resp_ready_i = 1'b0;
      chk({tag, "/resp_done"}, 64'(resp_valid_o), 64'd0);
      $display("txn %-10s addr=%h amo=%h rdata=%h err=%0b lat=%0d", tag, addr, amo,
               resp_rdata_o, resp_err_o, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_ni       = 1'b0;
      bank_init    = 1'b1;
      gnt_en       = 1'b1;
      resp_ready_i = 1'b0;
      drive_req(32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
      req_valid_i  = 1'b0;
      tick(); tick();
      chk("rst/ready", 64'(req_ready_o),  64'd1);
      chk("rst/valid", 64'(resp_valid_o), 64'd0);
      chk("rst/oreq",  64'(out_req_o),    64'd0);
      chk("rst/rdata", 64'(resp_rdata_o), 64'd0);
      chk("rst/err",   64'(resp_err_o),   64'd0);
      bank_init = 1'b0;
      rst_ni    = 1'b1;
      tick();

      // name, addr, amo, wen, wdata, swap, be, exp_be, exp_wdata, exp_wen, exp_rdata, exp_err, stall, hold
      run_txn("add_hi",   32'h104, 4'h2, 1'b0, 32'h5,    32'h0, 4'h0, 8'hF0,
              64'h00000005_00000005, 1'b0, 32'h0000000A, 1'b0, 0, 0);
      run_txn("swap_hi",  32'h10C, 4'h1, 1'b0, 32'hDEAD, 32'h0, 4'h0, 8'hF0,
              64'h0000DEAD_0000DEAD, 1'b0, 32'h11112222, 1'b0, 0, 0);
      run_txn("cas_lo",   32'h0,   4'hA, 1'b0, 32'h7,    32'h9, 4'h0, 8'h0F,
              64'h00000009_00000007, 1'b0, 32'h00000007, 1'b0, 0, 0);
      run_txn("cas_hi",   32'h4,   4'hA, 1'b0, 32'h7,    32'h9, 4'h0, 8'h00,
              64'h0, 1'b0, 32'h0, 1'b1, 0, 0);
      run_txn("amo_misal", 32'h102, 4'h2, 1'b0, 32'h1,   32'h0, 4'h0, 8'h00,
              64'h0, 1'b0, 32'h0, 1'b1, 0, 0);
      run_txn("bad_op",   32'h100, 4'hB, 1'b0, 32'h1,    32'h0, 4'h0, 8'h00,
              64'h0, 1'b0, 32'h0, 1'b1, 0, 0);
      run_txn("store",    32'h6,   4'h0, 1'b1, 32'hAABBCCDD, 32'h0, 4'b0011, 8'b0011_0000,
              64'hAABBCCDD_AABBCCDD, 1'b1, 32'h0, 1'b0, 3, 0);
      run_txn("load_hold", 32'h4,  4'h0, 1'b0, 32'h0,    32'h0, 4'hF, 8'hF0,
              64'h0, 1'b0, 32'h0000CCDD, 1'b0, 0, 5);
      run_txn("add_b2b_1", 32'h100, 4'h2, 1'b0, 32'h1,   32'h0, 4'h0, 8'h0F,
              64'h00000001_00000001, 1'b0, 32'h3, 1'b0, 0, 0);
      run_txn("add_b2b_2", 32'h100, 4'h2, 1'b0, 32'h2,   32'h0, 4'h0, 8'h0F,
              64'h00000002_00000002, 1'b0, 32'h4, 1'b0, 0, 0);
      run_txn("load_lo",  32'h100, 4'h0, 1'b0, 32'h0,    32'h0, 4'hF, 8'h0F,
              64'h0, 1'b0, 32'h6, 1'b0, 0, 0);
      run_txn("load_hi",  32'h104, 4'h0, 1'b0, 32'h0,    32'h0, 4'hF, 8'hF0,
              64'h0, 1'b0, 32'hF, 1'b0, 0, 0);

      // Reset while waiting for grant: the ungranted AMO must never reach the bank.
      gnt_en = 1'b0;
      drive_req(32'h100, 4'h2, 1'b0, 32'h50, 32'h0, 4'h0);
      tick();
      req_valid_i = 1'b0;
      chk("rst_issue/oreq_pre", 64'(out_req_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("rst_issue/oreq",  64'(out_req_o),    64'd0);
      chk("rst_issue/ready", 64'(req_ready_o),  64'd1);
      chk("rst_issue/valid", 64'(resp_valid_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      gnt_en = 1'b1;
      tick();
      $display("txn %-10s addr=%h amo=%h aborted in issue", "rst_issue", 32'h100, 4'h2);

      // Reset while the response is being held.
      drive_req(32'h100, 4'h0, 1'b0, 32'h0, 32'h0, 4'hF);
      tick();
      req_valid_i = 1'b0;
      n = 0;
      while (!resp_valid_o && n < 20) begin
         tick();
         n++;
      end
      chk("rst_resp/valid_pre", 64'(resp_valid_o), 64'd1);
      chk("rst_resp/rdata_pre", 64'(resp_rdata_o), 64'd6);
      rst_ni = 1'b0;
      #1;
      chk("rst_resp/valid", 64'(resp_valid_o), 64'd0);
      chk("rst_resp/rdata", 64'(resp_rdata_o), 64'd0);
      chk("rst_resp/err",   64'(resp_err_o),   64'd0);
      chk("rst_resp/ready", 64'(req_ready_o),  64'd1);
      tick();
      rst_ni = 1'b1;
      tick();
      $display("txn %-10s addr=%h amo=%h aborted in resp", "rst_resp", 32'h100, 4'h0);

      run_txn("post_rst", 32'h100, 4'h0, 1'b0, 32'h0, 32'h0, 4'hF, 8'h0F,
              64'h0, 1'b0, 32'h6, 1'b0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
